// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register and a one-entry skid buffer.
// Optional performance counters are compiled in when FETCH_PERF_EN is defined.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        freeze,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instr_d,
  output logic [31:0] npc_d,
  output logic        valid_d,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] HELD   = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] skid;
  logic [31:0] pc_plus4;

  // Memory handshake: imemREN is the request, ihit the response; a cycle with
  // imemREN & ihit transfers imemload for address imemaddr, otherwise the same
  // address stays requested. imemREN never depends on ihit.
  assign pc_plus4  = pc + 32'd4;
  assign imemaddr  = pc;
  assign imemREN   = (state == RUN) && !RST;
  assign state_dbg = state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= RUN;
      pc      <= PC_INIT;
      skid    <= 32'd0;
      instr_d <= 32'd0;
      npc_d   <= 32'd0;
      valid_d <= 1'b0;
    end else if (halt) begin
      state   <= HALTED;
      instr_d <= 32'd0;
      npc_d   <= 32'd0;
      valid_d <= 1'b0;
    end else if (state == RUN || state == HELD) begin
      if (redirect_valid) begin
        pc      <= {redirect_pc[31:2], 2'b00};
        skid    <= 32'd0;
        state   <= RUN;
        instr_d <= 32'd0;
        npc_d   <= 32'd0;
        valid_d <= 1'b0;
      end else if (flush) begin
        // A flushed hit still consumed its address, so pc moves on.
        instr_d <= 32'd0;
        npc_d   <= 32'd0;
        valid_d <= 1'b0;
        if (state == HELD) begin
          skid  <= 32'd0;
          state <= RUN;
        end else if (ihit) begin
          pc <= pc_plus4;
        end
      end else if (state == HELD) begin
        if (!freeze) begin
          instr_d <= skid;
          npc_d   <= pc;
          valid_d <= 1'b1;
          state   <= RUN;
        end
      end else if (ihit) begin
        pc <= pc_plus4;
        if (freeze) begin
          skid  <= imemload;
          state <= HELD;
        end else begin
          instr_d <= imemload;
          npc_d   <= pc_plus4;
          valid_d <= 1'b1;
        end
      end else if (!freeze) begin
        instr_d <= 32'd0;
        npc_d   <= 32'd0;
        valid_d <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic        load_valid;
  logic [31:0] fetch_q;
  logic [31:0] stall_q;

  // Mirrors the priority chain above: only an unsquashed, unfrozen load counts.
  assign load_valid = !RST && !halt && !redirect_valid && !flush && !freeze &&
                      ((state == RUN && ihit) || state == HELD);

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_q <= 32'd0;
      stall_q <= 32'd0;
    end else begin
      if (load_valid) fetch_q <= fetch_q + 32'd1;
      if (imemREN && !ihit) stall_q <= stall_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_q;
  assign stall_cnt = stall_q;
`else
  assign fetch_cnt = 32'd0;
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the fetch stage.
module tb_fetch_stage;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_HELD   = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic        CLK;
  logic        RST;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        freeze;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] instr_d;
  logic [31:0] npc_d;
  logic        valid_d;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
  logic [1:0]  state_dbg;

  fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .freeze(freeze), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .instr_d(instr_d), .npc_d(npc_d), .valid_d(valid_d),
    .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_errors = 0;

  // reference model: exp_q holds fetched words still waiting to reach decode
  logic [31:0] exp_q[$];
  logic [31:0] m_pc, m_instr, m_npc;
  logic        m_valid, m_halted;
  logic [31:0] m_fetch, m_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef FETCH_PERF_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  task automatic bubble();
    m_instr = 32'd0; m_npc = 32'd0; m_valid = 1'b0;
  endtask

  task automatic deliver(input logic [31:0] w, input logic [31:0] npc);
    m_instr = w; m_npc = npc; m_valid = 1'b1; m_fetch = m_fetch + 1;
  endtask

  task automatic model_step(input logic r, input logic ih, input logic [31:0] d,
                            input logic fr, input logic fl, input logic rv,
                            input logic [31:0] rp, input logic h);
    bit fetching;
    fetching = !m_halted && exp_q.size() == 0;
    if (r) begin
      exp_q.delete();
      m_pc = 32'd0; m_halted = 1'b0; bubble();
      m_fetch = 32'd0; m_stall = 32'd0;
    end else begin
      if (fetching && !ih) m_stall = m_stall + 1;
      if (h) begin
        m_halted = 1'b1; bubble();
      end else if (m_halted) begin
        // stuck until reset
      end else if (rv) begin
        m_pc = rp & 32'hFFFF_FFFC; exp_q.delete(); bubble();
      end else if (fl) begin
        bubble();
        if (exp_q.size() != 0) exp_q.delete();
        else if (ih) m_pc = m_pc + 4;
      end else if (exp_q.size() != 0) begin
        if (!fr) deliver(exp_q.pop_front(), m_pc);
      end else if (ih) begin
        m_pc = m_pc + 4;
        if (fr) exp_q.push_back(d);
        else deliver(d, m_pc);
      end else if (!fr) begin
        bubble();
      end
    end
  endtask

  task automatic check_all();
    logic [1:0] st;
    st = m_halted ? ST_HALTED : (exp_q.size() != 0 ? ST_HELD : ST_RUN);
    check("instr_d", instr_d, m_instr);
    check("npc_d", npc_d, m_npc);
    check("valid_d", {31'd0, valid_d}, {31'd0, m_valid});
    check("imemaddr", imemaddr, m_pc);
    check("imemREN", {31'd0, imemREN}, {31'd0, st == ST_RUN && !RST});
    check("state", {30'd0, state_dbg}, {30'd0, st});
    check("fetch_cnt", fetch_cnt, perf(m_fetch));
    check("stall_cnt", stall_cnt, perf(m_stall));
  endtask

  // driver: apply inputs at the falling edge, check after the next rising edge
  task automatic step(input logic r, input logic ih, input logic [31:0] d,
                      input logic fr, input logic fl, input logic rv,
                      input logic [31:0] rp, input logic h);
    RST = r; ihit = ih; imemload = d; freeze = fr; flush = fl;
    redirect_valid = rv; redirect_pc = rp; halt = h;
    model_step(r, ih, d, fr, fl, rv, rp, h);
    @(negedge CLK);
    check_all();
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  logic [31:0] pc_before;

  initial begin
    RST = 1; ihit = 0; imemload = 0; freeze = 0; flush = 0;
    redirect_valid = 0; redirect_pc = 0; halt = 0;
    @(negedge CLK);
    do_reset();
    check("rst_valid", {31'd0, valid_d}, 32'd0);
    check("rst_ren", {31'd0, imemREN}, 32'd0);

    // streaming hits
    for (int i = 0; i < 3; i++) begin
      step(0, 1, m_pc ^ 32'hA5A5_A5A5, 0, 0, 0, 0, 0);
      check("addr_seq", imemaddr, 32'd4 * (i + 1));
      check("instr_seq", instr_d, (32'd4 * i) ^ 32'hA5A5_A5A5);
    end

    // hit under freeze, held for three cycles, then release
    step(0, 1, 32'hCAFE_0001, 1, 0, 0, 0, 0);
    step(0, 1, 32'hDEAD_0000, 1, 0, 0, 0, 0);
    step(0, 1, 32'hDEAD_0001, 1, 0, 0, 0, 0);
    check("held_state", {30'd0, state_dbg}, {30'd0, ST_HELD});
    check("held_ren", {31'd0, imemREN}, 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("skid_out", instr_d, 32'hCAFE_0001);
    check("skid_npc", npc_d, 32'd16);

    // redirect while held drops the skid word
    step(0, 1, 32'h1234_5678, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 32'h0000_0103, 0);
    check("redir_addr", imemaddr, 32'h0000_0100);
    check("redir_valid", {31'd0, valid_d}, 32'd0);

    // flush + freeze + hit: bubble, pc still advances
    pc_before = m_pc;
    step(0, 1, 32'h5555_AAAA, 1, 1, 0, 0, 0);
    check("flush_valid", {31'd0, valid_d}, 32'd0);
    check("flush_pc", imemaddr, pc_before + 32'd4);

    // wrap at the top of the address space, then halt
    step(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFE, 0);
    step(0, 1, 32'h0BAD_F00D, 0, 0, 0, 0, 0);
    check("wrap_npc", npc_d, 32'd0);
    check("wrap_addr", imemaddr, 32'd0);
    step(0, 1, 32'h1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1'($urandom_range(0, 1)), $urandom, 0, 0, 1'($urandom_range(0, 1)), $urandom, 0);
      check("halt_ren", {31'd0, imemREN}, 32'd0);
    end

    // three hits and two misses for the counters
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, $urandom, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    check("perf_fetch", fetch_cnt, perf(32'd3));
    check("perf_stall", stall_cnt, perf(32'd2));

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rp;
      rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, $urandom,
           $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0, rp, $urandom_range(0, 79) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
